// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver,
// with sticky overflow and framing-error flags.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              MHz10,
  input  logic              nrst,
  input  logic              en,
  input  logic              rx_done,
  input  logic              rx_stop,
  input  logic [7:0]        rx_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_err
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic              good, bad, push, pop, clr;
  always_comb begin
    good    = en && rx_done && rx_stop;
    bad     = en && rx_done && !rx_stop;
    empty   = level == '0;
    full    = level == (ADDR_W+1)'(DEPTH);
    pop     = en && rd_en && !empty;
    push    = good && (!full || pop);
    clr     = en && clr_err;
    rd_data = empty ? 8'h00 : mem[rp];
  end
  // Storage is deliberately left out of reset; level gates every read.
  always_ff @(posedge MHz10)
    if (push) mem[wp] <= rx_data;
  always_ff @(posedge MHz10 or negedge nrst)
    if (!nrst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wp        <= push ? wp + 1'b1 : wp;
      rp        <= pop ? rp + 1'b1 : rp;
      level     <= (push && !pop) ? level + 1'b1 : (pop && !push) ? level - 1'b1 : level;
      overflow  <= (good && !push) ? 1'b1 : clr ? 1'b0 : overflow;
      frame_err <= bad ? 1'b1 : clr ? 1'b0 : frame_err;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the receive FIFO with DEPTH=8.
module tb_uart_rx_fifo;
  logic       MHz10 = 1'b0;
  logic       nrst = 1'b0, en = 1'b1, rx_done = 1'b0, rx_stop = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] rd_data;
  logic       empty, full, overflow, frame_err;
  logic [3:0] level;
  int         checks = 0, errors = 0;

  uart_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .MHz10(MHz10), .nrst(nrst), .en(en), .rx_done(rx_done), .rx_stop(rx_stop),
    .rx_data(rx_data), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #50 MHz10 = ~MHz10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge MHz10);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic rd, input logic clr);
    rx_done = 1'b1; rx_stop = stop; rx_data = d; rd_en = rd; clr_err = clr;
    tick();
    rx_done = 1'b0; rx_stop = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  initial begin
    #20;
    chk_reset("reset");
    tick();
    nrst = 1'b1;
    tick();
    chk_reset("post_reset");
    // basic ordering
    frame(8'hA5, 1, 0, 0);
    chk("first_rd_data", rd_data, 8'hA5);
    frame(8'h3C, 1, 0, 0);
    frame(8'hFF, 1, 0, 0);
    chk("level3", level, 3);
    pop("pop_a5", 8'hA5);
    pop("pop_3c", 8'h3C);
    pop("pop_ff", 8'hFF);
    chk("drained_empty", empty, 1);
    chk("drained_rd_data", rd_data, 8'h00);
    // fill and overflow
    for (int i = 1; i <= 8; i++) frame(8'(i), 1, 0, 0);
    chk("full_after8", full, 1);
    chk("level8", level, 8);
    chk("no_ovf_yet", overflow, 0);
    frame(8'h09, 1, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("level_still8", level, 8);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_cleared", overflow, 0);
    // push and pop together while full
    chk("head_01", rd_data, 8'h01);
    frame(8'h55, 1, 1, 0);
    chk("full_pushpop_level", level, 8);
    chk("full_pushpop_ovf", overflow, 0);
    for (int i = 2; i <= 8; i++) pop("drain", 8'(i));
    pop("drain_55", 8'h55);
    chk("drain_empty", empty, 1);
    // framing errors
    frame(8'h77, 0, 0, 0);
    chk("ferr_set", frame_err, 1);
    chk("ferr_level", level, 0);
    frame(8'h77, 0, 0, 1);
    chk("ferr_set_wins", frame_err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ferr_cleared", frame_err, 0);
    // interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++) begin
      frame(8'(i * 13 + 7), 1, 0, 0);
      chk("wrap_level", level, 1);
      pop("wrap_data", 8'(i * 13 + 7));
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("empty_pop_level", level, 0);
    chk("empty_pop_empty", empty, 1);
    chk("empty_pop_rd_data", rd_data, 8'h00);
    // empty with simultaneous rd_en and push
    frame(8'h42, 1, 1, 0);
    chk("empty_pushpop_level", level, 1);
    chk("empty_pushpop_data", rd_data, 8'h42);
    pop("pop_42", 8'h42);
    // asynchronous reset with state present
    for (int i = 0; i < 9; i++) frame(8'(8'hC0 + i), 1, 0, 0);
    for (int i = 0; i < 3; i++) pop("pre_rst_pop", 8'(8'hC0 + i));
    frame(8'h11, 0, 0, 0);
    chk("pre_rst_level", level, 5);
    chk("pre_rst_ovf", overflow, 1);
    chk("pre_rst_ferr", frame_err, 1);
    #10 nrst = 1'b0;
    #1 chk_reset("async_rst");
    tick();
    nrst = 1'b1;
    // disabled block ignores traffic
    en = 1'b0;
    frame(8'hAA, 1, 0, 0);
    chk("dis_level", level, 0);
    chk("dis_empty", empty, 1);
    frame(8'hAA, 0, 0, 0);
    chk("dis_ferr", frame_err, 0);
    en = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver in the 10 MHz domain. It captures each received byte on the receiver's one-cycle `done` strobe, discards frames whose stop bit is low, and holds accepted bytes in a small first-word-fall-through FIFO for the consuming logic. Sticky overflow and framing-error flags report lost data until software or control logic clears them.

## Interface
- `DEPTH`, 8, number of byte entries; must be a power of two, 2..16
- `ADDR_W`, 3, pointer width; must equal log2(`DEPTH`)
- `MHz10`  in  1  system clock, 10 MHz, rising-edge
- `nrst`  in  1  reset, asynchronous, active-low
- `en`  in  1  global enable; when low, all state holds
- `rx_done`  in  1  receiver stop-check strobe, high for exactly one cycle per frame
- `rx_stop`  in  1  live serial line, sampled in the `rx_done` cycle as the stop bit
- `rx_data`  in  8  receiver parallel byte, valid during `rx_done`
- `rd_en`  in  1  consumer pop request
- `rd_data`  out  8  head-of-FIFO byte; 8'h00 when empty
- `empty`  out  1  no bytes stored
- `full`  out  1  `DEPTH` bytes stored
- `level`  out  `ADDR_W`+1  number of bytes stored, 0..`DEPTH`
- `overflow`  out  1  sticky: a good frame arrived while full and was dropped
- `frame_err`  out  1  sticky: a frame arrived with a low stop bit
- `clr_err`  in  1  synchronous clear of `overflow` and `frame_err`

## Operation
- Storage: `DEPTH` x 8 register array, plus write pointer `wp`, read pointer `rp` (`ADDR_W` bits each) and `level` (`ADDR_W`+1 bits). The array is not reset.
- Good frame: `en && rx_done && rx_stop`. Bad frame: `en && rx_done && !rx_stop`.
- Push condition: good frame and (`!full` or pop this cycle). Writes `rx_data` to `mem[wp]` and increments `wp` modulo `DEPTH`.
- Pop condition: `en && rd_en && !empty`. Increments `rp` modulo `DEPTH`. A pop while empty is ignored, with no error.
- `level` update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- `empty = (level == 0)`, `full = (level == DEPTH)`. Both are combinational from registered `level`.
- `rd_data = empty ? 8'h00 : mem[rp]`, a combinational read of the registered array (FWFT).
- Full and good frame with no pop: byte dropped, `overflow` set, pointers unchanged.
- Full and good frame with pop in the same cycle: byte accepted, `level` stays `DEPTH`, no overflow.
- Empty and good frame with `rd_en` in the same cycle: pop ignored, byte accepted, `level` becomes 1.
- Bad frame: nothing stored, `frame_err` set.
- Sticky flags: set on the event, cleared by `en && clr_err`. If set and clear coincide, set wins.
- `en` low: no push, no pop, no flag change. An `rx_done` pulse arriving while `en` is low is lost by design, because the receiver is also frozen.
- Pointer wrap: `wp` and `rp` roll over from `DEPTH`-1 to 0. Full and empty are never derived from pointer equality.

## Timing
- Reset values: `wp`=`rp`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `frame_err`=0, `rd_data`=8'h00.
- Reset mid-operation clears all stored bytes and flags immediately (asynchronous).
- Write latency is 1 cycle: after a push at edge N, `empty` drops, `level` increments and `rd_data` shows the byte from edge N.
- Pop: `rd_data` shows the byte before the edge; the next entry (or 8'h00) appears after the edge.
- Flags assert on the edge that ends the `rx_done` cycle.
- Back-to-back `rx_done` pulses are supported, although the receiver cannot produce them. One push is allowed per cycle.
- No combinational path from `rx_*` or `rd_en` to any output, except `rd_data`/`empty`/`full` through registered state.

## Test plan
- Reset, then three good frames 8'hA5, 8'h3C, 8'hFF -> `level`=3; three pops return A5, 3C, FF in order, then `empty`=1 and `rd_data`=8'h00.
- Nine good frames 8'h01..8'h09 with no pops (`DEPTH`=8) -> `full`=1 after the 8th, 09 dropped, `overflow`=1, pops return 01..08.
- While full, a good frame 8'h55 coinciding with `rd_en` -> `level` stays 8, `overflow` stays 0, the last pop of the drain returns 55.
- `rx_done` with `rx_stop`=0 and `rx_data`=8'h77 -> `frame_err`=1, `level` unchanged; `clr_err` asserted in the same cycle as a new bad frame -> `frame_err` stays 1; `clr_err` alone -> 0.
- Twenty interleaved push/pop pairs crossing the wrap point -> data order preserved, `level` never exceeds 1; `rd_en` while empty -> no change.
- `nrst` pulsed low with `level`=5 and both flags set -> all outputs return to reset values immediately; a good frame with `en`=0 -> ignored.
